// File: rtl/draw_sequencer.sv
// draw_sequencer: writable draw-instruction store walked in order and
// handed to the drawing datapath over a valid/ready handshake.
// Ports:
//   clk_i, reset_i                      clock, sync active-high reset
//   wr_en_i/wr_addr_i/wr_x_i/wr_y_i/
//   wr_ch_i/wr_last_i                   instruction load port
//   start_i, loop_mode_i, abort_i       run control
//   out_valid_o, out_ready_i            downstream handshake
//   next_x_o, next_y_o, ch_o            presented instruction
//   pc_o, busy_o, done_o                status
module draw_sequencer #(
  parameter int X_W    = 10,
  parameter int Y_W    = 10,
  parameter int CH_W   = 3,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [X_W-1:0]    wr_x_i,
  input  logic [Y_W-1:0]    wr_y_i,
  input  logic [CH_W-1:0]   wr_ch_i,
  input  logic              wr_last_i,
  input  logic              start_i,
  input  logic              loop_mode_i,
  input  logic              abort_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [X_W-1:0]    next_x_o,
  output logic [Y_W-1:0]    next_y_o,
  output logic [CH_W-1:0]   ch_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int W = X_W + Y_W + CH_W + 1;
  localparam logic [ADDR_W:0] DEPTH_W =
    (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_PC =
    ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE, FETCH, VALID, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [W-1:0]      mem_q [DEPTH];
  logic [X_W-1:0]    x_q;
  logic [Y_W-1:0]    y_q;
  logic [CH_W-1:0]   ch_q;
  logic              last_q;
  logic              wr_ok;
  logic              hs;
  logic              term;

  // Out-of-range slots and reset-cycle writes are dropped.
  assign wr_ok = wr_en_i && !reset_i &&
                 ({1'b0, wr_addr_i} < DEPTH_W);

  // Nonblocking write gives old data on a same-slot read.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem_q[wr_addr_i] <=
        {wr_x_i, wr_y_i, wr_ch_i, wr_last_i};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q    <= '0;
      y_q    <= '0;
      ch_q   <= '0;
      last_q <= 1'b0;
    end else if (state_q == FETCH && !abort_i) begin
      {x_q, y_q, ch_q, last_q} <= mem_q[pc_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign hs   = (state_q == VALID) && out_ready_i;
  // Program ends on the last flag or on the final slot.
  assign term = last_q || (pc_q == LAST_PC);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      IDLE: begin
        pc_d = '0;
        if (start_i) state_d = FETCH;
      end
      FETCH: state_d = VALID;
      VALID: begin
        if (hs) begin
          if (term) begin
            pc_d    = '0;
            state_d = loop_mode_i ? FETCH : DONE;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        pc_d = '0;
        if (start_i) state_d = FETCH;
      end
      default: begin
        state_d = IDLE;
        pc_d    = '0;
      end
    endcase
    if (abort_i) begin
      state_d = IDLE;
      pc_d    = '0;
    end
  end

  assign out_valid_o = (state_q == VALID);
  assign busy_o      = (state_q == FETCH) ||
                       (state_q == VALID);
  assign done_o      = (state_q == DONE);
  assign pc_o        = pc_q;
  assign next_x_o    = x_q;
  assign next_y_o    = y_q;
  assign ch_o        = ch_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed bench for draw_sequencer (DEPTH=4 so the slot-count
// bound and the out-of-range write are both reachable).
module tb_draw_sequencer;

  localparam int X_W = 10;
  localparam int Y_W = 10;
  localparam int CH_W = 3;
  localparam int ADDR_W = 8;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [X_W-1:0]    wr_x = '0;
  logic [Y_W-1:0]    wr_y = '0;
  logic [CH_W-1:0]   wr_ch = '0;
  logic              wr_last = 1'b0;
  logic              start = 1'b0;
  logic              loop_mode = 1'b0;
  logic              abort = 1'b0;
  logic              out_ready = 1'b1;
  logic              out_valid;
  logic [X_W-1:0]    next_x;
  logic [Y_W-1:0]    next_y;
  logic [CH_W-1:0]   ch;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;

  int n_cmp = 0;
  int n_err = 0;

  draw_sequencer #(
    .X_W(X_W), .Y_W(Y_W), .CH_W(CH_W),
    .ADDR_W(ADDR_W), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .reset_i(reset),
    .wr_en_i(wr_en),
    .wr_addr_i(wr_addr),
    .wr_x_i(wr_x),
    .wr_y_i(wr_y),
    .wr_ch_i(wr_ch),
    .wr_last_i(wr_last),
    .start_i(start),
    .loop_mode_i(loop_mode),
    .abort_i(abort),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .next_x_o(next_x),
    .next_y_o(next_y),
    .ch_o(ch),
    .pc_o(pc),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input int x,
                    input int y, input int c,
                    input logic l);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(a);
    wr_x    = X_W'(x);
    wr_y    = Y_W'(y);
    wr_ch   = CH_W'(c);
    wr_last = l;
    step();
    wr_en   = 1'b0;
  endtask

  task automatic beat(input string tag, input int p,
                      input int x, input int y,
                      input int c);
    chk({tag, ".valid"}, 32'(out_valid), 1);
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".x"}, 32'(next_x), 32'(x));
    chk({tag, ".y"}, 32'(next_y), 32'(y));
    chk({tag, ".ch"}, 32'(ch), 32'(c));
  endtask

  task automatic rst_state(input string tag);
    chk({tag, ".valid"}, 32'(out_valid), 0);
    chk({tag, ".x"}, 32'(next_x), 0);
    chk({tag, ".y"}, 32'(next_y), 0);
    chk({tag, ".ch"}, 32'(ch), 0);
    chk({tag, ".pc"}, 32'(pc), 0);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
  endtask

  initial begin
    // reset
    step();
    step();
    reset = 1'b0;
    rst_state("reset");

    // load program
    wr(0, 50, 60, 0, 1'b0);
    wr(1, 100, 80, 2, 1'b0);
    wr(2, 150, 120, 4, 1'b1);
    wr(3, 200, 150, 5, 1'b0);
    chk("idle.busy", 32'(busy), 0);

    // basic run, ready always high
    start = 1'b1;
    step();
    start = 1'b0;
    chk("run.fetch.busy", 32'(busy), 1);
    chk("run.fetch.valid", 32'(out_valid), 0);
    step();
    beat("run.b0", 0, 50, 60, 0);
    step();
    chk("run.gap0", 32'(out_valid), 0);
    step();
    beat("run.b1", 1, 100, 80, 2);
    step();
    chk("run.gap1", 32'(out_valid), 0);
    step();
    beat("run.b2", 2, 150, 120, 4);
    step();
    chk("run.done", 32'(done), 1);
    chk("run.busy", 32'(busy), 0);
    chk("run.pc", 32'(pc), 0);
    chk("run.valid", 32'(out_valid), 0);

    // stall on second beat
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("stall.b0", 0, 50, 60, 0);
    step();
    out_ready = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      beat("stall.hold", 1, 100, 80, 2);
      step();
    end
    beat("stall.hold", 1, 100, 80, 2);
    out_ready = 1'b1;
    step();
    chk("stall.fetch", 32'(out_valid), 0);
    chk("stall.fetch.pc", 32'(pc), 2);
    step();
    beat("stall.b2", 2, 150, 120, 4);
    step();
    chk("stall.done", 32'(done), 1);

    // loop mode then abort mid-VALID
    loop_mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("loop.valid", 32'(out_valid), 1);
      chk("loop.pc", 32'(pc), 32'(k % 3));
      chk("loop.nodone", 32'(done), 0);
      step();
      chk("loop.nodone", 32'(done), 0);
    end
    step();
    beat("loop.b1", 1, 100, 80, 2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    loop_mode = 1'b0;
    chk("abort.valid", 32'(out_valid), 0);
    chk("abort.pc", 32'(pc), 0);
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);

    // no last flag: stop on slot-count bound
    wr(2, 150, 120, 4, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("wrap.b0", 0, 50, 60, 0);
    step();
    step();
    beat("wrap.b1", 1, 100, 80, 2);
    step();
    step();
    beat("wrap.b2", 2, 150, 120, 4);
    step();
    step();
    beat("wrap.b3", 3, 200, 150, 5);
    step();
    chk("wrap.done", 32'(done), 1);
    chk("wrap.pc", 32'(pc), 0);

    // write collides with FETCH of slot 1
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("col.b0", 0, 50, 60, 0);
    step();
    chk("col.fetch.pc", 32'(pc), 1);
    wr_en = 1'b1;
    wr_addr = 8'd1;
    wr_x = 10'd7;
    wr_y = 10'd9;
    wr_ch = 3'd1;
    wr_last = 1'b0;
    step();
    wr_en = 1'b0;
    beat("col.old", 1, 100, 80, 2);
    // out-of-range write while running
    wr_en = 1'b1;
    wr_addr = 8'(DEPTH);
    wr_x = 10'd511;
    wr_y = 10'd511;
    wr_ch = 3'd7;
    wr_last = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    beat("col.b2", 2, 150, 120, 4);
    step();
    step();
    beat("col.b3", 3, 200, 150, 5);
    step();
    chk("col.done", 32'(done), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("col.r0", 0, 50, 60, 0);
    step();
    step();
    beat("col.new", 1, 7, 9, 1);

    // reset with start and write in VALID
    out_ready = 1'b0;
    reset = 1'b1;
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 8'd0;
    wr_x = 10'd1;
    wr_y = 10'd2;
    wr_ch = 3'd3;
    wr_last = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    wr_en = 1'b0;
    out_ready = 1'b1;
    rst_state("rst2");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    beat("rst2.b0", 0, 50, 60, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("end.idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised, writable successor to the fixed draw-command ROM. It stores up to DEPTH draw instructions, each holding an X coordinate, a Y coordinate, a channel/colour code and a last flag. When started, it walks them in order and presents each one to the downstream drawing unit over a valid/ready handshake. It supports run-time loading, end-of-program marking, loop mode and abort, and sits between the host/loader and the pixel/line drawing datapath.

## Interface

Parameters:
- X_W, 10, X coordinate width
- Y_W, 10, Y coordinate width
- CH_W, 3, channel/colour code width
- ADDR_W, 8, program-counter/address width
- DEPTH, 256, number of instruction slots; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write one instruction this cycle
- wr_addr  in  ADDR_W  write slot
- wr_x  in  X_W  X to store
- wr_y  in  Y_W  Y to store
- wr_ch  in  CH_W  channel to store
- wr_last  in  1  marks the final instruction of the program
- start  in  1  begin execution at slot 0 (level, sampled in IDLE/DONE)
- loop_mode  in  1  1 = restart at slot 0 after last, 0 = stop
- abort  in  1  terminate execution immediately
- out_valid  out  1  next_x/next_y/ch hold a valid instruction
- out_ready  in  1  downstream accepts the instruction
- next_x  out  X_W  instruction X
- next_y  out  Y_W  instruction Y
- ch  out  CH_W  instruction channel
- pc  out  ADDR_W  slot currently fetched or presented
- busy  out  1  high in FETCH and VALID
- done  out  1  high while in DONE

## Operation

- Storage: DEPTH × (X_W+Y_W+CH_W+1) memory with synchronous read. It is not cleared by reset, and unwritten slots are undefined. Writes with wr_addr ≥ DEPTH are ignored. Writes are accepted in any state.
- Read/write collision on the same slot in the same cycle: the read returns the old data.
- FSM states are IDLE, FETCH, VALID and DONE.
  - IDLE: pc=0. start moves to FETCH.
  - FETCH: memory is read at pc. Always moves to VALID next cycle, and the registered data drives next_x/next_y/ch.
  - VALID: out_valid=1. The outputs hold stable until out_valid & out_ready. On handshake:
    - If the instruction's last flag is set or pc==DEPTH-1, then pc←0. The next state is FETCH if loop_mode=1, otherwise DONE.
    - Otherwise pc←pc+1 and the next state is FETCH.
  - DONE: done=1 and pc=0. start moves to FETCH, re-running from slot 0.
- loop_mode is sampled at the terminating handshake only.
- start is ignored in FETCH and VALID.
- abort in any state moves to IDLE next cycle with pc←0, out_valid←0 and done←0. abort has priority over start and over a handshake in the same cycle.
- next_x/next_y/ch keep their last value when out_valid=0. Downstream ignores them.
- pc arithmetic is ADDR_W bits unsigned. pc never exceeds DEPTH-1.

## Timing

- Reset values: out_valid=0, next_x=0, next_y=0, ch=0, pc=0, busy=0, done=0, state IDLE.
- reset has priority over abort, start and wr_en. A write in the reset cycle is dropped.
- start high in cycle t (IDLE) → FETCH in t+1 → out_valid=1 with slot 0 data in t+2.
- A handshake in cycle k → out_valid=0 in k+1 (FETCH) → next instruction valid in k+2. Peak throughput is one instruction per 2 cycles.
- A terminating handshake in cycle k with loop_mode=0 → done=1 from k+1 and busy=0 from k+1.
- abort in cycle k → out_valid=0, busy=0, done=0 from k+1.
- A write in cycle w is visible to a FETCH in cycle w+1 or later.

## Test plan

- Load (50,60,0), (100,80,2), (150,120,4, last), loop_mode=0, out_ready=1, pulse start → three valid beats every 2 cycles with those values and pc 0,1,2, then done=1 and busy=0.
- Same program with out_ready held low 5 cycles on the second beat → out_valid stays high and (100,80,2) holds stable. It advances only after out_ready rises.
- loop_mode=1 → beat sequence 0,1,2,0,1,… continues; done never asserts. abort mid-VALID → out_valid=0 and pc=0 the next cycle.
- No last flag set and DEPTH=4, slots 0–3 written → stops after pc=3 (wrap bound), then done=1.
- Write slot 1 = (7,9,1) in the same cycle FETCH reads slot 1 → old value presented. The next run presents (7,9,1). A write to wr_addr=DEPTH leaves memory unchanged.
- reset asserted mid-VALID together with start and wr_en → all outputs go to reset values next cycle, and the write is dropped.
